// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic array.
//   state_t        : controller states
//   flush_cycles() : cycles for the last beat to cross the skew and PE grid
//   sat_max/min()  : accumulator clamp limits, wide; callers truncate to ACC_W
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

  function automatic logic [127:0] sat_max(input int acc_w);
    return (128'(1) << (acc_w - 1)) - 128'(1);
  endfunction

  // Low acc_w bits are 1000...0, i.e. -2^(acc_w-1).
  function automatic logic [127:0] sat_min(input int acc_w);
    return ~sat_max(acc_w);
  endfunction

endpackage

// File: rtl/systolic_array_os_if.sv
// Job, operand and result handshake bundle for systolic_array_os.
//   start/k_len         : job request, sampled in IDLE
//   in_valid/in_ready   : operand beat, a_data = column k of A, b_data = row k of B
//   out_valid/out_ready : result row, out_row = index, out_data = C[out_row][*]
//   busy/done           : job status
// master = producer/consumer side, slave = the array.
interface systolic_array_os_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int N      = 4,
  parameter int K_W    = 8
);
  logic                   start;
  logic [K_W-1:0]         k_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*DATA_W-1:0]    a_data;
  logic [N*DATA_W-1:0]    b_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(N)-1:0]   out_row;
  logic [N*ACC_W-1:0]     out_data;
  logic                   busy;
  logic                   done;

  modport master (
    output start, k_len, in_valid, a_data, b_data, out_ready,
    input  in_ready, out_valid, out_row, out_data, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_data, b_data, out_ready,
    output in_ready, out_valid, out_row, out_data, busy, done
  );
endinterface

// File: rtl/systolic_pe_mac.sv
// One processing element: registered a/b/tag pass-through to the right and
// lower neighbours, and a tagged multiply-accumulate.
//   clk, rst              : clock, synchronous active-high reset
//   clr                   : zero the accumulator (job start)
//   a_in/a_tag_in         : operand from the left
//   b_in/b_tag_in         : operand from above
//   a_out/b_out (+tags)   : registered copies for the neighbours
//   acc                   : accumulator
// Build option SYSTOLIC_SATURATE_EN: clamp accumulation instead of wrapping.
module systolic_pe_mac
  import systolic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     a_tag_in,
  input  logic                     b_tag_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     a_tag_out,
  output logic                     b_tag_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_nxt;

  assign prod     = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
  assign prod_ext = ACC_W'(prod);

`ifdef SYSTOLIC_SATURATE_EN
  // One extra bit exposes overflow: top two bits disagree.
  logic signed [ACC_W:0] sum_wide;
  assign sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);

  always_comb begin
    acc_nxt = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      if (sum_wide[ACC_W]) acc_nxt = ACC_W'(sat_min(ACC_W));
      else                 acc_nxt = ACC_W'(sat_max(ACC_W));
    end
  end
`else
  assign acc_nxt = acc + prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      a_tag_out <= 1'b0;
      b_tag_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      a_tag_out <= a_tag_in;
      b_tag_out <= b_tag_in;
      if (clr)                       acc <= '0;
      else if (a_tag_in && b_tag_in) acc <= acc_nxt;
    end
  end

  // Skew depths make the a and b tags arrive together by construction.
  tag_align: assert property (@(posedge clk) disable iff (rst) a_tag_in == b_tag_in);

endmodule

// File: rtl/systolic_array_os.sv
// N x N output-stationary systolic matrix multiply, C = A x B over K beats.
//   clk, rst : clock, synchronous active-high reset
//   bus      : systolic_array_os_if.slave (job, operand and result handshakes)
// Each beat carries column k of A and row k of B; row i / column j are
// delayed i / j cycles internally, and results drain one row per accept.
// Build option SYSTOLIC_SATURATE_EN (in systolic_pe_mac): saturating accumulate.
module systolic_array_os
  import systolic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int N      = 4,
  parameter int K_W    = 8
) (
  input logic               clk,
  input logic               rst,
  systolic_array_os_if.slave bus
);

  localparam int ROW_W   = $clog2(N);
  localparam int FLUSH_N = flush_cycles(N);
  localparam int FLUSH_W = $clog2(FLUSH_N);

  state_t             state, state_nxt;
  logic               clr;
  logic               accept;
  logic [K_W-1:0]     beats_left;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [ROW_W-1:0]   row_idx;
  logic               done_q;

  logic signed [DATA_W-1:0] a_h  [N][N+1];
  logic                     at_h [N][N+1];
  logic signed [DATA_W-1:0] b_v  [N+1][N];
  logic                     bt_v [N+1][N];
  logic signed [ACC_W-1:0]  acc_grid [N][N];

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    clr           = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          clr = 1'b1;
          if (bus.k_len == '0) state_nxt = DRAIN;
          else                 state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && beats_left == K_W'(1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && row_idx == ROW_W'(N-1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // beats_left and flush_cnt are down-counters; each phase ends on its terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_left <= '0;
      flush_cnt  <= '0;
      row_idx    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (state == IDLE && bus.start) beats_left <= bus.k_len;
      else if (accept)                beats_left <= beats_left - K_W'(1);
      if (state == COMPUTE && state_nxt == FLUSH) flush_cnt <= FLUSH_W'(FLUSH_N - 1);
      else if (state == FLUSH)                    flush_cnt <= flush_cnt - FLUSH_W'(1);
      if (state == IDLE && bus.start) row_idx <= '0;
      else if (bus.out_valid && bus.out_ready)
        row_idx <= (row_idx == ROW_W'(N-1)) ? '0 : row_idx + ROW_W'(1);
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.out_row = row_idx;

  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < N; j++) bus.out_data[j*ACC_W +: ACC_W] = acc_grid[row_idx][j];
  end

  // Skew: lane i of A and of B is delayed i cycles. Each stage holds {tag, data};
  // the newest entry enters at the LSB and the oldest leaves at the MSB.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DATA_W-1:0] a_lane, b_lane;
    assign a_lane = bus.a_data[i*DATA_W +: DATA_W];
    assign b_lane = bus.b_data[i*DATA_W +: DATA_W];

    if (i == 0) begin : g_direct
      assign a_h[0][0]  = a_lane;
      assign at_h[0][0] = accept;
      assign b_v[0][0]  = b_lane;
      assign bt_v[0][0] = accept;
    end else begin : g_delay
      logic [i*(DATA_W+1)-1:0] a_pipe, b_pipe;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_pipe <= '0;
          b_pipe <= '0;
        end else begin
          a_pipe <= (i*(DATA_W+1))'({a_pipe, accept, a_lane});
          b_pipe <= (i*(DATA_W+1))'({b_pipe, accept, b_lane});
        end
      end
      assign {at_h[i][0], a_h[i][0]} = a_pipe[i*(DATA_W+1)-1 -: DATA_W+1];
      assign {bt_v[0][i], b_v[0][i]} = b_pipe[i*(DATA_W+1)-1 -: DATA_W+1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .a_in      (a_h[i][j]),
        .b_in      (b_v[i][j]),
        .a_tag_in  (at_h[i][j]),
        .b_tag_in  (bt_v[i][j]),
        .a_out     (a_h[i][j+1]),
        .b_out     (b_v[i+1][j]),
        .a_tag_out (at_h[i][j+1]),
        .b_tag_out (bt_v[i+1][j]),
        .acc       (acc_grid[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Self-checking bench for systolic_array_os: a matrix-product model in plain
// arithmetic, one negedge compare process for the result rows, and directed
// jobs with literal latency and value expectations.
// Honours SYSTOLIC_SATURATE_EN in its arithmetic model.
module tb_systolic_array_os;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int N      = 4;
  localparam int K_W    = 8;
  localparam int KMAX   = 8;
  localparam longint MODV = longint'(1) << ACC_W;
  localparam longint MAXV = MODV / 2 - 1;
  localparam longint MINV = -(MODV / 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_array_os_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N(N), .K_W(K_W)) bus ();

  systolic_array_os #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N(N), .K_W(K_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint a_m [N][KMAX];
  longint b_m [KMAX][N];
  longint c_exp [N][N];

  int exp_row = 0;
  int first_ov_cyc = -1;
  int done_cyc = -1;
  bit done_seen = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint acc_step(input longint acc, input longint p);
    longint s;
    s = acc + p;
`ifdef SYSTOLIC_SATURATE_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`else
    s = s % MODV;
    if (s > MAXV) s -= MODV;
    if (s < MINV) s += MODV;
`endif
    return s;
  endfunction

  task automatic compute_model(input int k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint acc;
        acc = 0;
        for (int kk = 0; kk < k; kk++) acc = acc_step(acc, a_m[i][kk] * b_m[kk][j]);
        c_exp[i][j] = acc;
      end
  endtask

  function automatic logic [N*ACC_W-1:0] row_vec(input int r);
    logic [N*ACC_W-1:0] v;
    for (int j = 0; j < N; j++) v[j*ACC_W +: ACC_W] = ACC_W'(c_exp[r][j]);
    return v;
  endfunction

  task automatic fill_const(input longint av, input longint bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        a_m[i][k] = av;
        b_m[k][i] = bv;
      end
  endtask

  task automatic fill_random;
    logic signed [DATA_W-1:0] r;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        r = DATA_W'($urandom);
        a_m[i][k] = r;
        r = DATA_W'($urandom);
        b_m[k][i] = r;
      end
  endtask

  task automatic drive_beat(input int kk);
    for (int i = 0; i < N; i++) begin
      bus.a_data[i*DATA_W +: DATA_W] = DATA_W'(a_m[i][kk]);
      bus.b_data[i*DATA_W +: DATA_W] = DATA_W'(b_m[kk][i]);
    end
  endtask

  // Result rows: the DUT must present model rows in order, holding each until accepted.
  always @(negedge clk) begin
    if (rst) begin
      exp_row = 0;
    end else begin
      if (bus.out_valid) begin
        if (first_ov_cyc < 0) first_ov_cyc = cyc;
        chk("out_row", bus.out_row, exp_row);
        if (exp_row < N) chk("out_data", bus.out_data, row_vec(exp_row));
        else             chk("row_in_range", exp_row, N - 1);
        if (bus.out_ready) exp_row++;
      end
      if (bus.done) begin
        done_cyc  = cyc;
        done_seen = 1'b1;
        chk("done_after_rows", exp_row, N);
        exp_row = 0;
      end
    end
  end

  task automatic run_job(input int k, input bit bubbles, input int stall_row, input int stall_len,
                         output int s_cyc, output int first_acc, output int last_acc);
    int beats, slot, guard, stall_cnt;
    compute_model(k);
    done_seen    = 1'b0;
    first_ov_cyc = -1;
    bus.k_len = K_W'(k);
    bus.start = 1'b1;
    s_cyc = cyc;
    tick;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    beats = 0; slot = 0; guard = 0; first_acc = -1; last_acc = -1;
    while (beats < k && guard < 400) begin
      bus.in_valid = bubbles ? (slot % 3 == 0) : 1'b1;
      drive_beat(beats);
      if (bus.in_valid && bus.in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        beats++;
      end
      tick;
      slot++;
      guard++;
    end
    if (beats < k) chk("beat_timeout", beats, k);
    if (k > 0) chk("in_ready_low_after_kth", bus.in_ready, 0);
    guard = 0; stall_cnt = 0;
    while (!done_seen && guard < 300) begin
      if (bus.out_valid && int'(bus.out_row) == stall_row && stall_cnt < stall_len) begin
        bus.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.out_ready = 1'b1;
      end
      tick;
      guard++;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    if (!done_seen) chk("done_timeout", 0, 1);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s, fa, la;
    rst = 1'b1;
    bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0;
    bus.a_data = '0; bus.b_data = '0; bus.out_ready = 1'b1;
    repeat (3) tick;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst = 1'b0;
    tick;

    // Identity A, B[k][j] = 10k+j: rows out equal B.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        a_m[i][k] = (i == k) ? 1 : 0;
        b_m[k][i] = 10 * k + i;
      end
    run_job(4, 1'b0, -1, 0, s, fa, la);
    chk("t1_model_c23", c_exp[2][3], 23);
    chk("t1_model_c31", c_exp[3][1], 31);
    chk("t1_start_to_beat", fa - s, 1);
    chk("t1_last_to_valid", first_ov_cyc - la, 2 * N);
    chk("t1_last_to_done", done_cyc - la, 3 * N + 1);
    chk("t1_valid_to_done", done_cyc - first_ov_cyc, N + 1);

    // K=1 outer product.
    for (int i = 0; i < N; i++) begin
      a_m[i][0] = i + 1;
      b_m[0][i] = i + 5;
    end
    run_job(1, 1'b0, -1, 0, s, fa, la);
    chk("t2_model_c33", c_exp[3][3], 32);
    chk("t2_model_c00", c_exp[0][0], 5);
    chk("t2_last_to_valid", first_ov_cyc - la, 8);

    // Bubbles between beats, all ones.
    fill_const(1, 1);
    run_job(4, 1'b1, -1, 0, s, fa, la);
    chk("t3_model_c12", c_exp[1][2], 4);
    chk("t3_last_to_done", done_cyc - la, 3 * N + 1);

    // Random K=8 with row 1 stalled 3 cycles.
    fill_random();
    run_job(8, 1'b0, 1, 3, s, fa, la);
    chk("t4_last_to_done", done_cyc - la, 3 * N + 1 + 3);

    // Abort mid-COMPUTE, then a fresh job.
    fill_random();
    bus.k_len = K_W'(8);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      drive_beat(b);
      tick;
    end
    rst = 1'b1;
    tick;
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_data", bus.out_data, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick;
    fill_const(2, 2);
    run_job(2, 1'b0, -1, 0, s, fa, la);
    chk("t5_model_c11", c_exp[1][1], 8);

    // K=0: zeros straight to drain.
    fill_const(7, 9);
    run_job(0, 1'b0, -1, 0, s, fa, la);
    chk("t6_start_to_valid", first_ov_cyc - s, 1);
    chk("t6_valid_to_done", done_cyc - first_ov_cyc, N + 1);

    // Overflow: 3 x (-32768)^2.
    fill_const(-32768, -32768);
    run_job(3, 1'b0, -1, 0, s, fa, la);
`ifdef SYSTOLIC_SATURATE_EN
    chk("t7_model_sat", c_exp[0][0], 2147483647);
`else
    chk("t7_model_wrap", c_exp[0][0], -1073741824);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
